// File: rtl/dial_pkg.sv
// Shared types and constants for the dial command front-end.
// ASCII codes, parser state encoding and the default distance width.
package dial_pkg;

  localparam int DIST_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    DIGITS,
    SKIP,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Saturating decimal accumulator: value = value*10 + digit.
// The ovf pulse flags a digit that pushed the value past all-ones.
module decimal_accumulator
  import dial_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_dv,
  input  logic [3:0]        i_digit,
  output logic [DIST_W-1:0] o_value,
  output logic              o_ovf
);

  localparam int AW = DIST_W + 4;

  logic [DIST_W-1:0] r_val;
  logic [AW-1:0]     w_sum;
  logic              w_big;

  // four spare bits hold value*10+9 for any value
  assign w_sum = {4'd0, r_val} * AW'(10) + AW'(i_digit);
  assign w_big = |w_sum[AW-1:DIST_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
    end else if (i_clear) begin
      r_val <= '0;
    end else if (i_dv) begin
      r_val <= w_big ? '1 : w_sum[DIST_W-1:0];
    end
  end

  assign o_value = r_val;
  assign o_ovf   = i_dv & w_big;

endmodule

// File: rtl/rotation_cmd_parser.sv
// ASCII rotation-line parser ("R48\n") feeding the dial counter.
// One {direction, distance} command per well-formed line.
module rotation_cmd_parser
  import dial_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              valid,
  output logic              direction,
  output logic [DIST_W-1:0] distance,
  input  logic              ready,
  output logic [CNT_W-1:0]  cmd_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              overflow,
  output logic              done
);

  state_t           r_state;
  logic             r_in_rdy;
  logic             r_valid;
  logic             r_dir;
  logic             r_have;
  logic             r_end;
  logic             r_ovf;
  logic             r_done;
  logic [CNT_W-1:0] r_cmd;
  logic [CNT_W-1:0] r_err;

  logic              w_xfer;
  logic              w_dig;
  logic              w_lf;
  logic              w_cr;
  logic              w_eol;
  logic              w_rl;
  logic              w_clr;
  logic              w_dv;
  logic              w_acc_ovf;
  logic [DIST_W-1:0] w_acc;
  logic [7:0]        w_off;

  assign w_xfer = in_valid & r_in_rdy;
  assign w_dig  = is_digit(in_data);
  assign w_lf   = (in_data == CH_LF);
  assign w_cr   = (in_data == CH_CR);
  assign w_eol  = w_lf | w_cr;
  assign w_rl   = (in_data == CH_R) | (in_data == CH_L);
  assign w_off  = in_data - CH_0;
  assign w_clr  = w_xfer & (r_state == IDLE) & w_rl;
  assign w_dv   = w_xfer & (r_state == DIGITS) & w_dig;

  decimal_accumulator #(
    .DIST_W (DIST_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clr),
    .i_dv    (w_dv),
    .i_digit (w_off[3:0]),
    .o_value (w_acc),
    .o_ovf   (w_acc_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_in_rdy <= 1'b0;
      r_valid  <= 1'b0;
      r_dir    <= 1'b0;
      r_have   <= 1'b0;
      r_end    <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_cmd    <= '0;
      r_err    <= '0;
    end else begin
      if (w_acc_ovf) r_ovf <= 1'b1;
      unique case (r_state)
        IDLE: begin
          r_in_rdy <= 1'b1;
          if (w_xfer) begin
            unique case (1'b1)
              w_rl: begin
                r_dir  <= (in_data == CH_R);
                r_have <= 1'b0;
                if (in_last) begin
                  r_err    <= r_err + CNT_W'(1);
                  r_state  <= DONE;
                  r_done   <= 1'b1;
                  r_in_rdy <= 1'b0;
                end else begin
                  r_state <= DIGITS;
                end
              end
              w_eol: begin
                if (in_last) begin
                  r_state  <= DONE;
                  r_done   <= 1'b1;
                  r_in_rdy <= 1'b0;
                end
              end
              default: begin
                r_err <= r_err + CNT_W'(1);
                if (in_last) begin
                  r_state  <= DONE;
                  r_done   <= 1'b1;
                  r_in_rdy <= 1'b0;
                end else begin
                  r_state <= SKIP;
                end
              end
            endcase
          end
        end
        DIGITS: begin
          if (w_xfer) begin
            if (!(w_dig || w_eol)) begin
              r_err <= r_err + CNT_W'(1);
              if (in_last) begin
                r_state  <= DONE;
                r_done   <= 1'b1;
                r_in_rdy <= 1'b0;
              end else begin
                r_state <= SKIP;
              end
            end else if (w_lf || in_last) begin
              // in_last stands in for the missing newline
              if (r_have || w_dig) begin
                r_state  <= HOLD;
                r_valid  <= 1'b1;
                r_in_rdy <= 1'b0;
                r_end    <= in_last;
              end else begin
                r_err <= r_err + CNT_W'(1);
                if (in_last) begin
                  r_state  <= DONE;
                  r_done   <= 1'b1;
                  r_in_rdy <= 1'b0;
                end else begin
                  r_state <= IDLE;
                end
              end
            end else if (w_dig) begin
              r_have <= 1'b1;
            end
          end
        end
        SKIP: begin
          if (w_xfer && (w_lf || in_last)) begin
            if (in_last) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_in_rdy <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_cmd   <= r_cmd + CNT_W'(1);
            if (r_end) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= IDLE;
              r_in_rdy <= 1'b1;
            end
          end
        end
        DONE: begin
          r_in_rdy <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_rdy;
  assign valid     = r_valid;
  assign direction = r_dir;
  assign distance  = w_acc;
  assign cmd_count = r_cmd;
  assign err_count = r_err;
  assign overflow  = r_ovf;
  assign done      = r_done;

endmodule

// File: tb/tb_rotation_cmd_parser.sv
// Randomized and directed bench for rotation_cmd_parser.
// Expected commands come from a line-level model of the stream.
module tb_rotation_cmd_parser;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        valid;
  logic        direction;
  logic [15:0] distance;
  logic        ready;
  logic [15:0] cmd_count;
  logic [15:0] err_count;
  logic        overflow;
  logic        done;

  rotation_cmd_parser #(
    .DIST_W (16),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .valid     (valid),
    .direction (direction),
    .distance  (distance),
    .ready     (ready),
    .cmd_count (cmd_count),
    .err_count (err_count),
    .overflow  (overflow),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          m_cmd;
  int          m_err;
  bit          m_ovf;
  bit          rmode;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a line is a command iff, ignoring CRs, it is R/L plus >=1 digit
  function automatic void eval_line(input byte q[$]);
    longint v;
    bit     ok;
    if (q.size() == 0) return;
    ok = (q[0] == 8'h52 || q[0] == 8'h4C) && q.size() > 1;
    for (int i = 1; i < q.size(); i++)
      if (q[i] < 8'h30 || q[i] > 8'h39) ok = 0;
    if (!ok) begin
      m_err++;
      return;
    end
    v = 0;
    for (int i = 1; i < q.size(); i++) begin
      v = v * 10 + longint'(q[i] - 8'h30);
      if (v > 65535) v = 70000;
    end
    if (v > 65535) begin
      m_ovf = 1;
      v = 65535;
    end
    exp_q.push_back({q[0] == 8'h52, 16'(v)});
    m_cmd++;
  endfunction

  function automatic void model(input string s, input bit last);
    byte q[$];
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (c == 8'h0A) begin
        eval_line(q);
        q.delete();
      end else if (c != 8'h0D) begin
        q.push_back(c);
      end
    end
    if (last) eval_line(q);
  endfunction

  task automatic send_byte(input byte b, input bit last, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last, input int maxgap,
                          input bit use_model);
    if (use_model) model(s, last);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last && (i == s.len() - 1),
                maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic drain_compare();
    rmode = 0;
    ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("ncmd", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("cmd%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("cmd_count", 32'(cmd_count), 32'(m_cmd & 'hFFFF));
    chk("err_count", 32'(err_count), 32'(m_err & 'hFFFF));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    m_cmd = 0;
    m_err = 0;
    m_ovf = 0;
    exp_q.delete();
    got_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic string rand_line();
    string s;
    int    k;
    k = $urandom_range(0, 9);
    if (k <= 4) begin
      s = $urandom_range(0, 1) ? "R" : "L";
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        s = {s, $sformatf("%0d", $urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) s = {s, "\r"};
      s = {s, "\n"};
    end else if (k <= 6) begin
      s = $urandom_range(0, 1) ? "\n" : "\r\n";
    end else begin
      case ($urandom_range(0, 3))
        0: s = "R\n";
        1: s = {"L", $sformatf("%0d", $urandom_range(0, 9)), "x\n"};
        2: s = "7\n";
        default: s = "?R5\n";
      endcase
    end
    return s;
  endfunction

  initial begin : mon
    bit          pv;
    logic [15:0] pd;
    logic        pdir;
    pv = 0;
    pd = '0;
    pdir = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (pv)
          chk("hold", 32'({valid, direction, distance}), 32'({1'b1, pdir, pd}));
        if (valid && ready) got_q.push_back({direction, distance});
        pv   = valid && !ready;
        pdir = direction;
        pd   = distance;
      end else begin
        pv = 0;
      end
    end
  end

  initial begin : rdy_drv
    forever begin
      @(posedge clk);
      #1;
      if (rmode) ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    string t1[3];
    string s;
    int    lm;
    t1[0] = "L68\n";
    t1[1] = "R48\n";
    t1[2] = "L5\n";
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    ready    = 1'b0;
    rmode    = 0;
    m_cmd = 0;
    m_err = 0;
    m_ovf = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_cmd", 32'(cmd_count), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dist", 32'(distance), 0);
    chk("rst_dir", 32'(direction), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ready = 1'b1;
    foreach (t1[i]) begin
      send_str(t1[i], 0, 0, 1);
      chk("lat_valid", 32'(valid), 1);
      @(negedge clk);
      chk("lat_valid_drop", 32'(valid), 0);
      chk("lat_in_ready", 32'(in_ready), 1);
    end
    drain_compare();

    ready = 1'b0;
    send_str("R12\n", 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(valid), 1);
      chk("stall_dir", 32'(direction), 1);
      chk("stall_dist", 32'(distance), 12);
      chk("stall_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(valid), 0);
    chk("stall_release_in_ready", 32'(in_ready), 1);
    drain_compare();

    send_str("X9\nR\nR1a\n\r\nL7\r\n", 0, 1, 1);
    drain_compare();

    send_str("R99999\n", 0, 0, 1);
    drain_compare();
    chk("sat_dist", 32'(distance), 32'hFFFF);
    send_str("L2\n", 0, 0, 1);
    drain_compare();

    send_str("R3", 1, 0, 1);
    drain_compare();
    chk("last_done", 32'(done), 1);
    chk("last_in_ready", 32'(in_ready), 0);

    do_reset();
    ready = 1'b0;
    send_str("L9\n", 0, 0, 0);
    chk("pre_rst_valid", 32'(valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 0);
    chk("async_rst_cmd", 32'(cmd_count), 0);
    chk("async_rst_err", 32'(err_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ready = 1'b1;
    send_str("L1\n", 0, 0, 1);
    drain_compare();

    for (int r = 0; r < 6; r++) begin
      do_reset();
      s = "";
      for (int i = 0; i < 15; i++) s = {s, rand_line()};
      lm = $urandom_range(0, 2);
      if (lm == 2) s = s.substr(0, s.len() - 2);
      rmode = 1;
      send_str(s, lm != 0, 2, 1);
      drain_compare();
      chk("rand_done", 32'(done), 32'(lm != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rotation_cmd_parser.md
Name: rotation_cmd_parser

Overview:
- Hardware front-end that turns the ASCII puzzle input ("R48\n", "L5\n", ...) into rotation commands for the dial counter.
- Consumes a byte stream through a valid/ready handshake.
- Emits one {direction, distance} command per valid line on the dial's valid/direction/distance interface, stalling on the dial's ready.
- Replaces the file-parsing bench loop, so the full flow can run on an FPGA fed from UART/BRAM.

Parameters:
- DIST_W, 16, width of the distance field; matches the dial's distance port.
- CNT_W, 16, width of the line and error counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data holds a byte
- in_data  in  8  ASCII byte
- in_last  in  1  qualifies the final byte of the stream; acts as an implicit terminator after that byte
- in_ready  out  1  parser accepts a byte this cycle
- valid  out  1  command valid toward the dial
- direction  out  1  1 = R, 0 = L
- distance  out  DIST_W  decimal value parsed from the line
- ready  in  1  dial accepts the command
- cmd_count  out  CNT_W  commands handed off (valid && ready)
- err_count  out  CNT_W  malformed lines discarded
- overflow  out  1  sticky; a distance exceeded 2^DIST_W-1
- done  out  1  sticky; stream end processed and last command handed off

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, valid=0, direction=0, distance=0, cmd_count=0, err_count=0, overflow=0, done=0, in_ready=0 during reset.
- Byte transfer: a byte transfers on in_valid && in_ready.
- in_ready: 1 in IDLE, DIGITS and SKIP. 0 in HOLD and after done.
- FSM state IDLE:
  - 'R' or 'L': latch direction, clear accumulator, go to DIGITS.
  - '\n' or '\r': ignore (empty line / CR), stay.
  - Any other byte: err_count++, go to SKIP.
- FSM state DIGITS:
  - '0'-'9': acc = acc*10 + digit.
  - If the result exceeds 2^DIST_W-1, saturate acc to all-ones and set overflow. The line is still issued.
  - '\r': ignore.
  - '\n' with at least one digit: go to HOLD.
  - '\n' with no digits ("R\n"): err_count++, go to IDLE.
  - Any other byte: err_count++, go to SKIP.
- FSM state SKIP: discard bytes until '\n', then go to IDLE.
- FSM state HOLD:
  - valid=1 while direction and distance stay stable.
  - On valid && ready: cmd_count++, go to IDLE (or DONE if the stream ended).
  - valid must not drop before ready.
- FSM state DONE: done=1, in_ready=0. Only reset exits.
- Latency: the terminator byte is accepted in cycle N; valid=1 in cycle N+1. If ready is already 1 in N+1, the handoff completes in N+1 and in_ready=1 in N+2.
- Throughput: at most one byte per cycle; minimum 2 idle byte slots per command (terminator + HOLD).
- in_last handling:
  - Treated as if '\n' follows the byte.
  - In DIGITS with digits: go to HOLD, then DONE after the handoff.
  - Otherwise: go to DONE immediately; a partial malformed line counts err_count++.
  - If the last byte is itself '\n', no extra empty line is counted.
- Counters: wrap modulo 2^CNT_W.
- Accumulator arithmetic: computed at DIST_W+4 bits to detect overflow.
- Reset asserted mid-line or in HOLD: valid drops immediately (async); the partial command is lost, counters clear.

Decomposition:
- Shared package dial_pkg: state enum (IDLE, DIGITS, SKIP, HOLD, DONE); ASCII constants CH_R, CH_L, CH_LF, CH_CR, CH_0, CH_9; DIST_W default shared with the dial.
- One natural sub-module: decimal_accumulator (clear, digit-valid, digit[3:0] -> value, saturated flag). Everything else stays in the top FSM.

Test Plan:
- Stream "L68\nR48\nL5\n" with ready tied to 1 -> three commands: (0,68), (1,48), (0,5); cmd_count=3, err_count=0; each valid one cycle after its '\n'.
- "R12\n" with ready low for 5 cycles after valid rises -> valid held 5 cycles with direction=1, distance=12 stable; in_ready=0 throughout; one handoff.
- Malformed lines "X9\n", "R\n", "R1a\n", then "\r\n", then "L7\r\n" -> err_count=3, exactly one command (0,7).
- "R99999\n" with DIST_W=16 -> distance=16'hFFFF, overflow=1 and sticky.
- "R3" with in_last on '3' and no newline -> command (1,3) issued, then done=1, in_ready=0.
- rst_n pulsed low mid-HOLD -> valid=0 within the same cycle; counters 0; a following "L1\n" yields command (0,1).
